// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder: a small look-ahead buffer is matched against a sliding
// history window, one offset per cycle, producing (pos, len, next-char) codes.
module lz77_encoder #(
    parameter int          SEARCH_DEPTH = 7,
    parameter int          MAX_LEN      = 3,
    parameter logic [7:0]  TERM         = 8'h24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] chardata,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       encode,
    output logic       code_start,
    output logic [3:0] code_pos,
    output logic [2:0] code_len,
    output logic [7:0] char_nxt,
    output logic       finish
);

    localparam int LA_D = MAX_LEN + 1;
    localparam int LAW  = $clog2(LA_D);
    localparam int HW   = $clog2(SEARCH_DEPTH);
    localparam int CW   = $clog2(LA_D + 1);
    localparam int HCW  = $clog2(SEARCH_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, FILL, SEARCH, EMIT, DONE} state_t;

    state_t         state;
    logic [7:0]     la      [LA_D];
    logic [7:0]     la_n    [LA_D];
    logic [7:0]     hist    [SEARCH_DEPTH];
    logic [CW-1:0]  la_cnt, la_cnt_n, wr;
    logic [HCW-1:0] hist_cnt;
    logic           term_seen;
    logic [3:0]     sp, best_pos, fin_pos;
    logic [2:0]     best_len, fin_len, cand_len, hold_cnt;
    logic           rdy, acc, run, src_ok;
    logic [7:0]     src;

    always_comb begin
        rdy = 1'b0;
        case (state)
            IDLE:    rdy = 1'b1;
            FILL:    rdy = !term_seen && (la_cnt < CW'(LA_D));
            EMIT:    rdy = !term_seen;
            default: rdy = 1'b0;
        endcase
    end

    assign in_ready = rdy & ~reset;
    assign acc      = in_valid & in_ready;

    // Emission shifts the head out while a refill lands behind the shifted tail.
    always_comb begin
        la_n = la;
        wr   = la_cnt;
        if (state == EMIT) begin
            for (int i = 0; i < LA_D - 1; i++) la_n[LAW'(i)] = la[LAW'(i + 1)];
            wr = la_cnt - 1'b1;
        end
        if (acc) la_n[LAW'(wr)] = chardata;
        la_cnt_n = wr + CW'(acc);
    end

    // Source of look-ahead[k] at offset sp lies sp+1 characters earlier; once it
    // passes the history/look-ahead boundary the match runs on its own output.
    always_comb begin
        cand_len = '0;
        run      = 1'b1;
        src      = '0;
        src_ok   = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k > int'(sp)) begin
                src    = la[LAW'(k - int'(sp) - 1)];
                src_ok = 1'b1;
            end else begin
                src    = hist[HW'(int'(sp) - k)];
                src_ok = (int'(sp) - k) < int'(hist_cnt);
            end
            if (run && src_ok && src == la[LAW'(k)] && k < int'(la_cnt) - 1
                && la[LAW'(k)] != TERM)
                cand_len = cand_len + 1'b1;
            else
                run = 1'b0;
        end
    end

    assign fin_len = (cand_len > best_len) ? cand_len : best_len;
    assign fin_pos = (cand_len > best_len) ? sp : best_pos;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            la_cnt     <= '0;
            hist_cnt   <= '0;
            term_seen  <= 1'b0;
            sp         <= '0;
            best_len   <= '0;
            best_pos   <= '0;
            hold_cnt   <= '0;
            encode     <= 1'b0;
            code_start <= 1'b0;
            code_pos   <= '0;
            code_len   <= '0;
            char_nxt   <= '0;
            finish     <= 1'b0;
            for (int i = 0; i < LA_D; i++) la[LAW'(i)] <= '0;
            for (int i = 0; i < SEARCH_DEPTH; i++) hist[HW'(i)] <= '0;
        end else begin
            la     <= la_n;
            la_cnt <= la_cnt_n;
            if (acc && chardata == TERM) term_seen <= 1'b1;

            if (state == EMIT) begin
                hist[0] <= la[0];
                for (int i = 1; i < SEARCH_DEPTH; i++) hist[HW'(i)] <= hist[HW'(i - 1)];
                if (hist_cnt != HCW'(SEARCH_DEPTH)) hist_cnt <= hist_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (acc) begin
                        state  <= FILL;
                        encode <= 1'b1;
                    end
                end
                FILL: begin
                    if (la_cnt == CW'(LA_D) || term_seen) begin
                        state    <= SEARCH;
                        sp       <= '0;
                        best_len <= '0;
                        best_pos <= '0;
                    end
                end
                SEARCH: begin
                    best_len <= fin_len;
                    best_pos <= fin_pos;
                    if (sp == 4'(SEARCH_DEPTH - 1)) begin
                        state      <= EMIT;
                        code_start <= 1'b1;
                        code_pos   <= fin_pos;
                        code_len   <= fin_len;
                        char_nxt   <= la[LAW'(fin_len)];
                        hold_cnt   <= fin_len;
                    end else begin
                        sp <= sp + 1'b1;
                    end
                end
                EMIT: begin
                    code_start <= 1'b0;
                    if (hold_cnt == '0) begin
                        if (char_nxt == TERM) begin
                            state  <= DONE;
                            finish <= 1'b1;
                            encode <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_encoder.sv
// Scoreboard bench for lz77_encoder: a greedy LZ77 reference fills the expected
// queue, an independent monitor checks every code as the DUT presents it.
module tb_lz77_encoder;
    localparam int SD = 7;
    localparam int ML = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chardata;
    logic       in_valid;
    logic       in_ready, encode, code_start, finish;
    logic [3:0] code_pos;
    logic [2:0] code_len;
    logic [7:0] char_nxt;

    lz77_encoder #(.SEARCH_DEPTH(SD), .MAX_LEN(ML), .TERM(8'h24)) dut (
        .clk(clk), .reset(reset), .chardata(chardata), .in_valid(in_valid),
        .in_ready(in_ready), .encode(encode), .code_start(code_start),
        .code_pos(code_pos), .code_len(code_len), .char_nxt(char_nxt),
        .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        int len;
        int ch;
    } code_t;

    code_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void to_q(input string s, output byte q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    // Greedy LZ77 over the whole string: longest match (ties -> nearest) whose
    // source starts within SD characters back, leaving one char for char_nxt.
    function automatic void model(input byte s[$]);
        int n = s.size();
        int i = 0;
        while (i < n) begin
            int bl = 0, bp = 0;
            int lim = (n - i - 1 < ML) ? n - i - 1 : ML;
            code_t c;
            for (int p = 0; p < SD; p++) begin
                int j = i - p - 1;
                int l = 0;
                if (j >= 0)
                    while (l < lim && s[j + l] == s[i + l]) l++;
                if (l > bl) begin
                    bl = l;
                    bp = p;
                end
            end
            c.pos = bp;
            c.len = bl;
            c.ch  = int'(s[i + bl]);
            exp_q.push_back(c);
            i += bl + 1;
        end
    endfunction

    // Monitor: pops one expected code per code_start, checks field stability
    // while held and the exact hold length of the final code.
    code_t cur;
    int    hold;
    bit    active, fin_seen, stable_ok;
    logic [14:0] latched;

    always @(negedge clk) begin
        if (reset) begin
            active   = 1'b0;
            fin_seen = 1'b0;
        end else if (code_start) begin
            if (active) check("stable", int'(stable_ok), 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_code: got (%0d,%0d,%0h) expected none",
                         code_pos, code_len, char_nxt);
            end else begin
                cur = exp_q.pop_front();
                check("code_pos", int'(code_pos), cur.pos);
                check("code_len", int'(code_len), cur.len);
                check("char_nxt", int'(char_nxt), cur.ch);
                check("encode_on", int'(encode), 1);
            end
            active    = 1'b1;
            stable_ok = 1'b1;
            hold      = 1;
            latched   = {code_pos, code_len, char_nxt};
        end else if (active && !fin_seen) begin
            if ({code_pos, code_len, char_nxt} !== latched) stable_ok = 1'b0;
            if (finish) begin
                fin_seen = 1'b1;
                active   = 1'b0;
                check("final_hold", hold, cur.len + 1);
                check("stable", int'(stable_ok), 1);
                check("encode_off", int'(encode), 0);
            end else begin
                hold++;
            end
        end
    end

    task automatic send(input byte s[$], input int mode);
        int idx = 0, cyc = 0;
        bit acc, tog = 1'b1;
        while (idx < s.size() && cyc < 3000) begin
            @(negedge clk);
            chardata = s[idx];
            case (mode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = !tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            #1 acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        check("all_chars_accepted", idx, s.size());
    endtask

    task automatic wait_done();
        int cyc = 0, extra = 0;
        while (cyc < 500) begin
            @(negedge clk);
            if (finish) break;
            chardata = 8'h7a;
            in_valid = 1'b1;
            #1 if (in_ready) extra++;
            cyc++;
        end
        check("finish_reached", int'(finish), 1);
        check("post_term_accepts", extra, 0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("done_state", int'({finish, encode, in_ready}), 3'b100);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        chardata = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input string s, input int mode);
        byte q[$];
        to_q(s, q);
        do_reset();
        model(q);
        send(q, mode);
        wait_done();
    endtask

    initial begin
        byte q[$];
        int  seen, cyc;
        reset    = 1'b1;
        in_valid = 1'b0;
        chardata = '0;
        #1 check("reset_outputs",
                 int'({in_ready, encode, code_start, code_pos, code_len, char_nxt, finish}), 0);

        run("aaaa$", 0);
        run("abcabc$", 0);
        run("ababab$", 0);
        run("abcdefgha$", 0);
        run("abcabc$", 1);
        run("$", 0);

        // Reset in the middle of the second code's hold, then a fresh run.
        to_q("aaaa$", q);
        do_reset();
        model(q);
        seen = 0;
        cyc  = 0;
        fork
            send(q, 0);
        join_none
        while (seen < 2 && cyc < 500) begin
            @(negedge clk);
            if (code_start) seen++;
            cyc++;
        end
        check("second_code_seen", seen, 2);
        @(negedge clk);
        #2 reset = 1'b1;
        disable fork;
        in_valid = 1'b0;
        #1 check("midemit_reset_outputs",
                 int'({in_ready, encode, code_start, code_pos, code_len, char_nxt, finish}), 0);
        run("aaaa$", 0);

        for (int t = 0; t < 25; t++) begin
            byte r[$];
            int  n = $urandom_range(0, 15);
            r = {};
            for (int i = 0; i < n; i++) r.push_back(byte'(8'h61 + $urandom_range(0, 2)));
            r.push_back(8'h24);
            do_reset();
            model(r);
            send(r, $urandom_range(0, 2));
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lz77_encoder.md
Name: lz77_encoder

Overview:
- Streaming LZ77 compressor. Produces (code_pos, code_len, char_nxt) triples that the team's LZ77 decoder consumes directly.
- Accepts one 8-bit character per handshake and ends on the terminator '$' (0x24). Sits upstream of the decoder on the same code bus.
- Output codes are held stable at the decoder's consumption rate: one code for code_len+1 cycles.

Parameters:
- SEARCH_DEPTH, 7, number of history characters searched; code_pos range is 0..SEARCH_DEPTH-1.
- MAX_LEN, 3, maximum match length; look-ahead buffer depth is MAX_LEN+1.
- TERM, 8'h24, terminator character; always emitted as char_nxt of the last code.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- chardata  input  8  input character.
- in_valid  input  1  chardata valid.
- in_ready  output  1  character accepted on a cycle when in_valid && in_ready.
- encode  output  1  high from first accepted character until finish.
- code_start  output  1  one-cycle pulse on the first cycle of each new code.
- code_pos  output  4  match offset; 0 = most recent history character.
- code_len  output  3  match length, 0..MAX_LEN.
- char_nxt  output  8  literal character following the match.
- finish  output  1  sticky; set after the final code's last hold cycle.

Behaviour:
- Reset (async, any state): all outputs 0; history and look-ahead invalidated; history count 0; FSM to IDLE.
- History: shift register of SEARCH_DEPTH characters, entry 0 = most recent. Only entries below the valid count are matchable.
- FSM states:
  - IDLE: in_ready=1. On first accept, go to FILL and set encode=1.
  - FILL: in_ready=1 while look-ahead is not full and TERM not yet received. Go to SEARCH when look-ahead holds MAX_LEN+1 chars or contains TERM.
  - SEARCH: exactly SEARCH_DEPTH cycles, one offset p per cycle, in_ready=0.
    - Candidate length L(p) = consecutive matches of look-ahead[k] against the character p+1 positions before it.
    - Matches may overlap into the look-ahead, so runs are legal.
    - Capped so that at least one look-ahead character remains for char_nxt and TERM is never inside a match.
    - Keep the longest L; on ties keep the smallest p.
    - Invalid history gives L=0. If the best L=0, code_pos=0.
  - EMIT: load the code and pulse code_start; hold the fields stable for code_len+1 cycles.
    - Each cycle shifts one look-ahead character into history.
    - in_ready=1 during EMIT only while look-ahead has room after the shift, so the refill overlaps emission.
    - After the last cycle: if char_nxt==TERM go to DONE, else go to FILL.
  - DONE: finish=1, encode=0, in_ready=0. Code fields hold their last values. Stays until reset.
- Input handshake:
  - Characters after TERM are never accepted.
  - in_valid gaps stall FILL but do not alter emitted codes.
- Width rules:
  - code_pos is zero-extended from the search index.
  - code_len never exceeds MAX_LEN.
  - The look-ahead count and history count saturate at their depths.
- Boundaries:
  - Empty history at start forces literals.
  - A match source exactly SEARCH_DEPTH back is out of range.
  - A TERM-only look-ahead emits (0,0,TERM).
  - Reset mid-EMIT drops the current code with no partial finish.

Test Plan:
- "aaaa$" streamed with in_valid=1 -> codes (0,0,'a'), (0,3,'$'); each code_start pulse followed by 1 and 4 hold cycles respectively; finish=1 after.
- "abcabc$" -> (0,0,'a'), (0,0,'b'), (0,0,'c'), (2,3,'$'); encode falls as finish rises.
- "ababab$" -> (0,0,'a'), (0,0,'b'), (1,3,'b'), (0,0,'$'); checks overlapping match and the char_nxt cap.
- "abcdefgha$" (SEARCH_DEPTH=7) -> nine literal codes, final (0,0,'$'); checks out-of-window rejection.
- "abcabc$" with in_valid deasserted every other cycle -> identical code sequence to the gap-free run; no character accepted while in_ready=0.
- Assert reset during the hold of the second code, then stream "aaaa$" -> all outputs 0 immediately; fresh sequence identical to the first scenario; finish not set before its final code.
